pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Control block that owns and sequences the program counter of the single-cycle core. Each cycle it chooses the next fetch address from sequential, branch, jump, trap and return sources. It also applies stall and halt, runs a one-cycle boot phase after reset, and captures the exception PC. It sits between the decode/execute control signals and the instruction-memory address port, and replaces direct writes of the PC register.

## Interface
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset; must be word-aligned
- TRAP_VEC, 32'h0000_0100, trap handler address; must be word-aligned
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and all state this cycle
- branch_taken  in  1  conditional branch resolved taken
- branch_target  in  32  branch destination
- jump  in  1  JAL/JALR redirect
- jump_target  in  32  jump destination; bit 0 is cleared internally
- trap_req  in  1  illegal instruction or ecall at current pc
- mret  in  1  return from trap
- halt  in  1  ebreak; stop fetching
- resume  in  1  leave HALT
- pc  out  32  current fetch address (registered)
- pc_plus4  out  32  pc + 4, combinational, modulo 2^32
- epc  out  32  exception PC (registered)
- fetch_valid  out  1  pc is a valid fetch this cycle (registered)
- misaligned  out  1  one-cycle pulse: redirect target was not word-aligned
- state  out  2  FSM state (BOOT=0, RUN=1, HALT=2)

## Operation
- Reset values while reset=0: pc=BOOT_ADDR, epc=0, fetch_valid=0, misaligned=0, state=BOOT.
- BOOT
  - Lasts exactly one cycle after reset deasserts.
  - pc is held and all inputs are ignored.
  - Next state is RUN with fetch_valid=1.
- RUN, stall=1: pc, epc and state hold; misaligned=0; all requests are ignored. The requester holds its request until stall drops.
- RUN, stall=0: the next pc is chosen by this priority:
  1. trap_req: pc←TRAP_VEC, epc←pc.
  2. Misaligned redirect: the selected jump or branch target has bits[1:0]≠0 (jump after clearing bit 0). Then pc←TRAP_VEC, epc←pc, misaligned←1 for one cycle.
  3. mret: pc←epc.
  4. jump: pc←{jump_target[31:1],1'b0}.
  5. branch_taken: pc←branch_target.
  6. Otherwise: pc←pc_plus4.
- jump has priority over branch_taken when both are asserted; only the chosen target is checked for alignment.
- halt in RUN with stall=0 and no trap or misaligned redirect: pc←pc_plus4, state←HALT, fetch_valid←0. When halt coincides with jump, mret or branch, the redirect is taken and halt still applies.
- HALT
  - pc and epc hold and all redirect inputs are ignored.
  - resume=1 → state←RUN, fetch_valid←1, pc unchanged.
  - trap_req in HALT is ignored.
- Wrap-around: pc=32'hFFFF_FFFC with a sequential step gives 32'h0000_0000, with no flag.
- Reset asserted at any time forces reset values immediately (asynchronous), aborting any redirect in flight.

## Timing
- A request sampled at edge n takes effect on pc immediately after edge n. Latency is 1 cycle for every source.
- epc updates on the same edge as the trap redirect.
- misaligned is high for exactly the cycle following the offending edge.
- Once reset deasserts, the first valid fetch (fetch_valid=1) is at BOOT_ADDR, one cycle after BOOT.
- pc_plus4 is the only combinational output. Its path is pc register → adder.

## Structure
- Package pc_seq_pkg:
  - state enum (BOOT, RUN, HALT).
  - Source-select enum (SEQ, BR, JMP, RET, TRAP).
  - Constant PC_STEP = 32'd4.
  - Alignment-check function.
- Sub-module pc_next_mux (combinational): priority selection and alignment check; outputs the next pc and the source select.
- The top module holds the FSM and the pc, epc, fetch_valid and misaligned registers.

## Test plan
- Reset release with BOOT_ADDR=32'h40: one BOOT cycle at pc=0x40 with fetch_valid=0, then pc sequence 0x40, 0x44, 0x48 with fetch_valid=1.
- At pc=0x100, branch_taken=1 to 0x200 together with jump=1 to 0x301: pc→0x300 (jump wins, bit 0 cleared), misaligned=0.
- At pc=0x20, jump to 0x102: pc→0x100 (TRAP_VEC), epc=0x20, misaligned=1 for one cycle. Then mret → pc=0x20.
- stall=1 for 3 cycles with trap_req held at pc=0x80: pc stays 0x80. After stall drops, pc→TRAP_VEC with epc=0x80.
- At pc=0x50, halt: pc→0x54, state=HALT, fetch_valid=0. jump and trap_req are ignored during HALT. resume → RUN with pc=0x54.
- pc=32'hFFFF_FFFC with no request wraps to 0. Reset asserted mid-trap redirect gives pc=BOOT_ADDR and epc=0 immediately.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    BR   = 3'd1,
    JMP  = 3'd2,
    RET  = 3'd3,
    TRAP = 3'd4
  } pc_src_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return ~|(addr & 32'd3);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority selection of the next fetch address with redirect alignment check.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] epc,
  input  logic        trap_req,
  input  logic        mret,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output pc_src_e     src,
  output logic        redirect_misaligned
);

  logic [31:0] jmp_addr;
  logic [31:0] redir_addr;
  logic        redir_bad;

  // Only the winning redirect target (jump over branch) is alignment-checked.
  assign jmp_addr   = jump_target & ~32'd1;
  assign redir_addr = jump ? jmp_addr : branch_target;
  assign redir_bad  = (jump || branch_taken) && !is_word_aligned(redir_addr);

  always_comb begin
    next_pc             = pc_plus4;
    src                 = SEQ;
    redirect_misaligned = 1'b0;
    if (trap_req) begin
      next_pc = TRAP_VEC;
      src     = TRAP;
    end else if (redir_bad) begin
      next_pc             = TRAP_VEC;
      src                 = TRAP;
      redirect_misaligned = 1'b1;
    end else if (mret) begin
      next_pc = epc;
      src     = RET;
    end else if (jump) begin
      next_pc = jmp_addr;
      src     = JMP;
    end else if (branch_taken) begin
      next_pc = branch_target;
      src     = BR;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: boot phase, run/halt FSM, redirects and exception PC capture.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap_req,
  input  logic        mret,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        fetch_valid,
  output logic        misaligned,
  output logic [1:0]  state
);

  pc_state_e   st, st_n;
  logic [31:0] pc_n, epc_n;
  logic        fv_n, mis_n;
  logic [31:0] mux_pc;
  pc_src_e     mux_src;
  logic        mux_mis;

  assign pc_plus4 = pc + PC_STEP;
  assign state    = st;

  pc_next_mux #(
    .TRAP_VEC(TRAP_VEC)
  ) u_mux (
    .pc_plus4           (pc_plus4),
    .epc                (epc),
    .trap_req           (trap_req),
    .mret               (mret),
    .jump               (jump),
    .jump_target        (jump_target),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .next_pc            (mux_pc),
    .src                (mux_src),
    .redirect_misaligned(mux_mis)
  );

  always_comb begin
    st_n  = st;
    pc_n  = pc;
    epc_n = epc;
    fv_n  = fetch_valid;
    mis_n = 1'b0;
    case (st)
      BOOT: begin
        st_n = RUN;
        fv_n = 1'b1;
      end
      RUN: begin
        if (!stall) begin
          pc_n  = mux_pc;
          mis_n = mux_mis;
          // Halt still applies alongside a taken redirect, but not to a trap.
          if (mux_src == TRAP) begin
            epc_n = pc;
          end else if (halt) begin
            st_n = HALT;
            fv_n = 1'b0;
          end
        end
      end
      HALT: begin
        if (!stall && resume) begin
          st_n = RUN;
          fv_n = 1'b1;
        end
      end
      default: begin
        st_n = BOOT;
        fv_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= BOOT;
      pc          <= BOOT_ADDR;
      epc         <= '0;
      fetch_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      st          <= st_n;
      pc          <= pc_n;
      epc         <= epc_n;
      fetch_valid <= fv_n;
      misaligned  <= mis_n;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] BA = 32'h0000_0040;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        trap_req = 1'b0;
  logic        mret = 1'b0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc, pc_plus4, epc;
  logic        fetch_valid, misaligned;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: 0=BOOT, 1=RUN, 2=HALT
  logic [31:0] m_pc, m_epc;
  logic        m_fv, m_mis;
  int          m_st;

  pc_sequencer #(.BOOT_ADDR(BA), .TRAP_VEC(TV)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .trap_req(trap_req), .mret(mret), .halt(halt), .resume(resume),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
    .fetch_valid(fetch_valid), .misaligned(misaligned), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("epc", epc, m_epc);
    chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv});
    chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
    chk("state", {30'd0, state}, m_st[31:0]);
  endtask

  task automatic model_reset();
    m_pc = BA; m_epc = '0; m_fv = 1'b0; m_mis = 1'b0; m_st = 0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    logic        redirect;
    logic        mis_next;
    mis_next = 1'b0;
    if (m_st == 0) begin
      m_st = 1; m_fv = 1'b1;
    end else if (m_st == 1 && !stall) begin
      redirect = jump | branch_taken;
      tgt = jump ? {jump_target[31:1], 1'b0} : branch_target;
      if (trap_req || (redirect && (tgt % 4) != 0)) begin
        mis_next = !trap_req;
        m_epc = m_pc;
        m_pc = TV;
      end else begin
        if (mret) m_pc = m_epc;
        else if (redirect) m_pc = tgt;
        else m_pc = m_pc + 32'd4;
        if (halt) begin m_st = 2; m_fv = 1'b0; end
      end
    end else if (m_st == 2 && !stall && resume) begin
      m_st = 1; m_fv = 1'b1;
    end
    m_mis = mis_next;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; trap_req = 0;
    mret = 0; halt = 0; resume = 0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_jump(input logic [31:0] t);
    clear_inputs(); jump = 1; jump_target = t; tick(); clear_inputs();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("reset_pc", pc, BA);
    @(posedge clk); #1;
    reset = 1'b1;
    chk("boot_state", {30'd0, state}, 32'd0);
    chk("boot_fv", {31'd0, fetch_valid}, 32'd0);
    tick(); chk("first_fetch", pc, 32'h40);
    chk("first_fv", {31'd0, fetch_valid}, 32'd1);
    tick(); chk("seq1", pc, 32'h44);
    tick(); chk("seq2", pc, 32'h48);

    do_jump(32'h100);
    branch_taken = 1; branch_target = 32'h200; jump = 1; jump_target = 32'h301;
    tick(); clear_inputs();
    chk("jump_wins", pc, 32'h300);
    chk("jump_wins_mis", {31'd0, misaligned}, 32'd0);

    do_jump(32'h20);
    do_jump(32'h102);
    chk("mis_trap_pc", pc, TV);
    chk("mis_trap_epc", epc, 32'h20);
    chk("mis_pulse", {31'd0, misaligned}, 32'd1);
    tick(); chk("mis_cleared", {31'd0, misaligned}, 32'd0);
    mret = 1; tick(); clear_inputs();
    chk("mret_pc", pc, 32'h20);

    do_jump(32'h80);
    for (int i = 0; i < 3; i++) begin
      stall = 1; trap_req = 1; tick();
      chk("stall_hold", pc, 32'h80);
    end
    stall = 0; tick(); clear_inputs();
    chk("trap_pc", pc, TV);
    chk("trap_epc", epc, 32'h80);

    do_jump(32'h50);
    halt = 1; tick(); clear_inputs();
    chk("halt_pc", pc, 32'h54);
    chk("halt_state", {30'd0, state}, 32'd2);
    jump = 1; jump_target = 32'h300; trap_req = 1; tick(); clear_inputs();
    chk("halt_ignore", pc, 32'h54);
    resume = 1; tick(); clear_inputs();
    chk("resume_state", {30'd0, state}, 32'd1);
    chk("resume_pc", pc, 32'h54);

    do_jump(32'hFFFF_FFFC);
    tick(); chk("wrap", pc, 32'h0);

    trap_req = 1;
    #3 reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_pc", pc, BA);
    chk("async_rst_epc", epc, 32'h0);
    check_all();
    clear_inputs();
    @(posedge clk); #1;
    check_all();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      stall         = ($urandom_range(4) == 0);
      trap_req      = ($urandom_range(15) == 0);
      halt          = ($urandom_range(15) == 0);
      mret          = ($urandom_range(7) == 0);
      jump          = ($urandom_range(5) == 0);
      branch_taken  = ($urandom_range(3) == 0);
      resume        = ($urandom_range(2) == 0);
      jump_target   = $urandom;
      branch_target = $urandom;
      if ($urandom_range(3) != 0) begin
        jump_target   = {jump_target[31:2], 1'b0, jump_target[0]};
        branch_target = {branch_target[31:2], 2'b00};
      end
      tick();
    end
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
